flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer side of the branch-condition interface.
- Owns the architectural {Z,V,N} flag register that the branch/PC logic consumes as F[2:0] (F[2]=Z, F[1]=V, F[0]=N).
- Sits at the EX stage: takes the ALU result and opcode of the committing instruction and updates only the flags that opcode defines.
- Provides either a same-cycle bypass or a hazard/stall request to a branch in ID, plus a halt tracker.

Parameters:
- BYPASS, 1: 1 = forward next-cycle flags combinationally to ID; 0 = no forwarding, assert flag_hazard instead.
- DW, 16: ALU result width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_opcode  in  4  opcode of the EX instruction
- ex_result  in  DW  ALU result of the EX instruction
- ex_ovfl  in  1  signed overflow from the ALU (meaningful only for ADD/SUB)
- stall  in  1  pipeline stall; EX does not advance this cycle
- flush  in  1  kill EX instruction this cycle
- id_is_branch  in  1  ID holds opcode 1100 (B) or 1101 (BR)
- flags  out  3  registered {Z,V,N}
- flags_id  out  3  flags the ID-stage branch must use
- flag_hazard  out  1  request one-cycle ID stall
- halted  out  1  HLT has committed

Behaviour:
- Reset (rst_n=0 at a clk edge): flags=3'b000, state=RUN, halted=0. Reset wins over every other input, including mid-halt.
- commit = ex_valid & ~stall & ~flush & (state==RUN).
- Per-opcode flag updates, applied at the clk edge when commit=1; all other flags hold:
  - 0000 ADD, 0001 SUB: Z=(ex_result==0), V=ex_ovfl, N=ex_result[DW-1].
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z only; V and N hold.
  - 0011 RED, 0111 PADDSB, 1000-1110: no change.
  - 1111 HLT: no flag change; state RUN->HALTED.
- No commit (stall, flush, invalid, or HALTED): flags hold.
- flush and stall together: flush dominates; no update.
- State machine:
  - RUN->HALTED on commit of 1111.
  - HALTED is absorbing until reset; halted=1 from the cycle after the HLT edge.
  - In HALTED, ex_* inputs are ignored.
- sets_flags = ex_valid & ~flush & (state==RUN) & opcode in {0000,0001,0010,0100,0101,0110}.
- BYPASS=1:
  - flags_id = combinational next-flag value when sets_flags, else the flags register.
  - flag_hazard=0 always.
- BYPASS=0:
  - flags_id = flags.
  - flag_hazard = id_is_branch & sets_flags.
  - While stall=1, hazard may stay high. Once EX advances, flags are written, so the stalled branch sees the correct value next cycle (exactly 1 cycle of penalty).
- Latency: register update 1 clk after commit; bypass 0 clk.
- Arithmetic: Z is a full DW-bit zero compare; no sign extension. V is passed through, never recomputed.

Decomposition:
- Shared package wisc_pkg:
  - opcode localparams OP_ADD..OP_HLT;
  - flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0;
  - typedef flags_t (3-bit packed).
  - The PC/branch logic imports the same package.
- One combinational sub-module, flag_next: (opcode, result, ovfl, cur_flags) -> next_flags. It is instantiated once and feeds both the register D-input and the bypass path, so the two paths cannot diverge.

Test Plan:
1. Reset: hold rst_n=0 two cycles with ex_valid=1 ADD result 0 -> flags=000, halted=0. Then, with flags at 111 mid-run, assert rst_n=0 -> flags=000 next edge.
2. ADD: result 16'h8000, ovfl=1 -> flags=011 next cycle. Then SUB result 0, ovfl=0 -> 100.
3. Partial update: preload flags=011, XOR result 0 -> 111 (V, N retained). PADDSB result 0 -> unchanged 011.
4. Kill paths: SUB result 0 with flush=1 -> flags unchanged. Same with stall=1 for 3 cycles then stall=0 -> update occurs exactly once, after release.
5. Branch interaction, BYPASS=1: EX ADD result 0, id_is_branch=1 -> flags_id=100 in the same cycle, flag_hazard=0.
6. Branch interaction, BYPASS=0, same stimulus -> flag_hazard=1 for 1 cycle, then flags_id=100.
7. Halt: commit 1111 -> halted=1 next cycle. A subsequent ADD result 0 leaves flags unchanged. rst_n=0 -> halted=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared ISA constants and flag types for the WISC pipeline.
// Imported by the flag producer and the PC/branch consumer.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef logic [2:0] flags_t;

    function automatic logic op_sets_all(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_sets_z(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) ||
               (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/flag_next.sv
// Next-flag computation shared by the flag register and the ID bypass.
// Flags not defined by the opcode pass through from cur_flags.
module flag_next
    import wisc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] result,
    input  logic          ovfl,
    input  flags_t        cur_flags,
    output flags_t        next_flags
);

    logic is_arith;
    logic is_zonly;
    logic res_zero;

    assign is_arith = op_sets_all(opcode);
    assign is_zonly = op_sets_z(opcode);
    assign res_zero = (result == '0);

    always_comb begin
        next_flags = cur_flags;
        unique case (1'b1)
            is_arith: begin
                next_flags[FLAG_Z] = res_zero;
                next_flags[FLAG_V] = ovfl;
                next_flags[FLAG_N] = result[DW-1];
            end
            is_zonly: begin
                next_flags[FLAG_Z] = res_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// EX-stage {Z,V,N} flag register with ID bypass or hazard request,
// plus the RUN/HALTED tracker that freezes state after HLT commits.
module flag_unit
    import wisc_pkg::*;
#(
    parameter bit BYPASS = 1'b1,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_ovfl,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_is_branch,
    output flags_t        flags,
    output flags_t        flags_id,
    output logic          flag_hazard,
    output logic          halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0] state;
    flags_t     nxt_flags;
    logic       run;
    logic       commit;
    logic       sets_flags;

    assign run    = (state == ST_RUN);
    assign commit = ex_valid & ~stall & ~flush & run;

    assign sets_flags = ex_valid & ~flush & run &
        (op_sets_all(ex_opcode) | op_sets_z(ex_opcode));

    flag_next #(
        .DW(DW)
    ) u_next (
        .opcode    (ex_opcode),
        .result    (ex_result),
        .ovfl      (ex_ovfl),
        .cur_flags (flags),
        .next_flags(nxt_flags)
    );

    // Non-flag opcodes yield nxt_flags == flags, so commit alone gates the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= '0;
            state <= ST_RUN;
        end else if (commit) begin
            flags <= nxt_flags;
            if (ex_opcode == OP_HLT) state <= ST_HALTED;
        end
    end

    assign halted = (state == ST_HALTED);

    generate
        if (BYPASS) begin : g_byp
            assign flags_id    = sets_flags ? nxt_flags : flags;
            assign flag_hazard = 1'b0;
        end else begin : g_haz
            assign flags_id    = flags;
            assign flag_hazard = id_is_branch & sets_flags;
        end
    endgenerate

endmodule

// File: tb/tb_flag_unit.sv
// Directed plus randomized bench for flag_unit in both BYPASS modes.
// A per-opcode reference model predicts flags, bypass and hazard.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic        stall;
    logic        flush;
    logic        id_is_branch;

    logic [2:0]  flags1, fid1, flags0, fid0;
    logic        hz1, hz0, halt1, halt0;

    int checks = 0;
    int errors = 0;

    logic [2:0] m_flags;
    logic       m_halted;
    bit         m_known = 1'b0;

    always #5 clk = ~clk;

    flag_unit #(.BYPASS(1'b1), .DW(16)) u_byp (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush),
        .id_is_branch(id_is_branch), .flags(flags1),
        .flags_id(fid1), .flag_hazard(hz1), .halted(halt1)
    );

    flag_unit #(.BYPASS(1'b0), .DW(16)) u_nob (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush),
        .id_is_branch(id_is_branch), .flags(flags0),
        .flags_id(fid0), .flag_hazard(hz0), .halted(halt0)
    );

    function automatic bit op_writes(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    endfunction

    // Flags after an opcode: {Z, V, N}
    function automatic logic [2:0] ref_next(input logic [2:0] f,
                                            input logic [3:0] op,
                                            input logic [15:0] r,
                                            input logic v);
        case (op)
            4'h0, 4'h1: return {r == 16'd0, v, $signed(r) < 0};
            4'h2, 4'h4, 4'h5, 4'h6: return {r == 16'd0, f[1], f[0]};
            default: return f;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rn, input logic v,
                         input logic [3:0] op, input logic [15:0] r,
                         input logic o, input logic st,
                         input logic fl, input logic br);
        bit         wr;
        logic [2:0] nxt;
        rst_n = rn; ex_valid = v; ex_opcode = op; ex_result = r;
        ex_ovfl = o; stall = st; flush = fl; id_is_branch = br;
        #1;
        if (m_known) begin
            wr  = v && !fl && !m_halted && op_writes(op);
            nxt = ref_next(m_flags, op, r, o);
            chk("byp_flags_id", fid1, wr ? nxt : m_flags);
            chk("byp_hazard", hz1, 1'b0);
            chk("nob_flags_id", fid0, m_flags);
            chk("nob_hazard", hz0, br && wr);
        end
        @(posedge clk);
        if (!rn) begin
            m_flags = 3'b000; m_halted = 1'b0; m_known = 1'b1;
        end else if (m_known && v && !st && !fl && !m_halted) begin
            m_flags = ref_next(m_flags, op, r, o);
            if (op == 4'hF) m_halted = 1'b1;
        end
        #1;
        if (m_known) begin
            chk("byp_flags", flags1, m_flags);
            chk("nob_flags", flags0, m_flags);
            chk("byp_halted", halt1, m_halted);
            chk("nob_halted", halt0, m_halted);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] r;
        // Reset held two cycles with a live ADD of zero
        cycle(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0);
        cycle(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0);
        chk("reset_flags_const", flags1, 3'b000);
        // Build 111, then reset mid-run
        cycle(1, 1, 4'h0, 16'h8000, 1, 0, 0, 0);
        chk("add_8000_const", flags1, 3'b011);
        cycle(1, 1, 4'h2, 16'h0000, 0, 0, 0, 0);
        chk("xor_keep_vn_const", flags1, 3'b111);
        cycle(0, 1, 4'h1, 16'h1234, 0, 0, 0, 0);
        chk("midrun_reset_const", flags0, 3'b000);
        // ADD then SUB
        cycle(1, 1, 4'h0, 16'h8000, 1, 0, 0, 0);
        cycle(1, 1, 4'h1, 16'h0000, 0, 0, 0, 0);
        chk("sub_zero_const", flags1, 3'b100);
        // Partial updates from 011
        cycle(1, 1, 4'h0, 16'h8000, 1, 0, 0, 0);
        cycle(1, 1, 4'h7, 16'h0000, 0, 0, 0, 0);
        chk("paddsb_hold_const", flags1, 3'b011);
        cycle(1, 1, 4'h2, 16'h0000, 0, 0, 0, 0);
        // Flush, flush+stall, then a 3-cycle stall
        cycle(1, 1, 4'h1, 16'h0000, 0, 0, 1, 0);
        cycle(1, 1, 4'h1, 16'h0000, 0, 1, 1, 1);
        cycle(1, 1, 4'h0, 16'h8000, 1, 0, 0, 0);
        repeat (3) cycle(1, 1, 4'h1, 16'h0000, 0, 1, 0, 1);
        chk("stall_hold_const", flags1, 3'b011);
        cycle(1, 1, 4'h1, 16'h0000, 0, 0, 0, 0);
        chk("stall_release_const", flags1, 3'b100);
        cycle(1, 0, 4'h1, 16'h8000, 1, 0, 0, 0);
        // Branch in ID while EX sets flags
        cycle(1, 1, 4'h0, 16'hFFFF, 0, 0, 0, 0);
        cycle(1, 1, 4'h0, 16'h0000, 0, 0, 0, 1);
        chk("branch_fid_after_const", fid0, 3'b100);
        // Halt, ignored ADD, reset
        cycle(1, 1, 4'hF, 16'h8000, 1, 0, 0, 0);
        cycle(1, 1, 4'h0, 16'h0000, 1, 0, 0, 1);
        cycle(1, 1, 4'h0, 16'h8000, 1, 0, 0, 1);
        chk("halt_hold_const", flags1, 3'b100);
        cycle(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0);
        chk("halt_clear_const", halt1, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 5) != 0)
                op = 4'($urandom_range(0, 6));
            r = ($urandom_range(0, 3) == 0) ? 16'h0000
                                            : 16'($urandom);
            cycle($urandom_range(0, 39) != 0,
                  $urandom_range(0, 7) != 0, op, r,
                  1'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
